usb_host_xfer_ctrl: RTL and testbench
=====================================

USB_HOST_XFER_CTRL -- requirements
Module: usb_host_xfer_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, 64, page payload bits; PAGE_W, 16, mempage bits; MAX_BURST, 4, max pages per request; MAX_RETRY, 3, retries per page after the first attempt; TIMEOUT_CYCLES, 1024, engine watchdog limit.
REQ-002 Ports SHALL be: clock in 1, system clock; reset_n in 1, synchronous active-low reset.
REQ-003 SHALL have: req_valid in 1; req_ready out 1; req_write in 1, 1=write 0=read; req_page in PAGE_W, first page; req_len in $clog2(MAX_BURST+1), page count.
REQ-004 SHALL have: wr_data in DATA_W; wr_valid in 1; wr_ready out 1, per-page write payload handshake.
REQ-005 SHALL have: rd_data out DATA_W; rd_valid out 1, one-cycle pulse per page read.
REQ-006 SHALL have: done out 1, one-cycle pulse; done_ok out 1; fail_page out PAGE_W; retries_used out 8, total retries in last request.
REQ-007 Engine side SHALL have: eng_read_start out 1; eng_write_start out 1; eng_mempage out PAGE_W; eng_write_data out DATA_W; eng_finished in 1; eng_read_success in 1; eng_write_success in 1; eng_read_data in DATA_W.

Function
REQ-008 States SHALL be IDLE, FETCH, ISSUE, WAIT, CHECK, DONE.
REQ-009 IDLE: req_ready=1; on req_valid latch write/page/len (len 0 or >MAX_BURST clamped to 1 / MAX_BURST), clear retry and page counters; go FETCH if write else ISSUE.
REQ-010 FETCH: wr_ready=1; on wr_valid latch wr_data into eng_write_data, go ISSUE.
REQ-011 ISSUE: assert exactly one of eng_read_start/eng_write_start for one cycle with eng_mempage = start page + page index; go WAIT next cycle.
REQ-012 WAIT: hold eng_mempage and eng_write_data stable; on eng_finished go CHECK.
REQ-013 CHECK: success = eng_read_success (read) or eng_write_success (write); on success of read pulse rd_valid with rd_data = eng_read_data.
REQ-014 CHECK success: if last page go DONE with done_ok=1; else increment page index, go FETCH (write) or ISSUE (read).
REQ-015 CHECK failure: if page retry count < MAX_RETRY increment it and retries_used, go ISSUE reusing latched write data (no new wr handshake); else go DONE with done_ok=0, fail_page = failing page.
REQ-016 DONE: pulse done one cycle, return IDLE; done_ok, fail_page, retries_used hold until next request accepted.
REQ-017 Page retry count SHALL reset to 0 on each new page; page address SHALL wrap modulo 2^PAGE_W.
REQ-018 req_valid outside IDLE SHALL be ignored (req_ready=0); eng_finished outside WAIT SHALL be ignored.
REQ-019 retries_used SHALL saturate at 255.

Reset
REQ-020 reset_n low at a clock edge SHALL force IDLE from any state, abandoning the request with no done pulse.
REQ-021 Reset values: req_ready=1 after reset; all other outputs 0; counters 0.

Configuration
REQ-022 With USB_XFER_TIMEOUT_EN defined, a counter SHALL run in WAIT; reaching TIMEOUT_CYCLES without eng_finished SHALL be treated as a CHECK failure (retry rules apply).
REQ-023 Without USB_XFER_TIMEOUT_EN, WAIT SHALL wait indefinitely and no timeout logic SHALL exist.

Structure
REQ-024 State enum and default parameter constants SHALL live in USBPkg.
REQ-025 One sub-module, usb_xfer_watchdog (cycle counter, clear/enable/expired), SHALL exist, instantiated only under USB_XFER_TIMEOUT_EN.

Verification
REQ-026 Read req_page=0x0010 len=1, engine succeeds with data 0xDEADBEEF_CAFEF00D -> one rd_valid with that data, eng_mempage=0x0010, done with done_ok=1, retries_used=0.
REQ-027 Write len=3 at 0x0100, three wr payloads -> eng_write_start three times at 0x0100/0x0101/0x0102 in order, each preceded by a wr handshake, done_ok=1.
REQ-028 Read len=1, engine fails twice then succeeds -> three eng_read_start pulses, retries_used=2, done_ok=1.
REQ-029 Write len=2, page 2 fails 4 times (MAX_RETRY=3) -> done_ok=0, fail_page=start+1, retries_used=3, only one wr handshake for page 2.
REQ-030 req_page=0xFFFF len=2 -> pages 0xFFFF then 0x0000; reset_n low during WAIT -> IDLE next cycle, no done pulse.
REQ-031 With USB_XFER_TIMEOUT_EN, engine never finishes -> four ISSUE attempts each 1024 cycles apart, then done_ok=0.

Source files
------------

// File: rtl/usb_host_xfer_ctrl_pkg.sv
// ============================================================================
// Module   : USBPkg
// Purpose  : Shared state encoding and default parameters for the USB host
//            page-transfer controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package USBPkg;

    localparam int DEF_DATA_W         = 64;
    localparam int DEF_PAGE_W         = 16;
    localparam int DEF_MAX_BURST      = 4;
    localparam int DEF_MAX_RETRY      = 3;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } xfer_state_t;

endpackage

`default_nettype wire

// File: rtl/usb_host_xfer_ctrl_watchdog.sv
// ============================================================================
// Module   : usb_xfer_watchdog
// Purpose  : Cycle counter flagging an engine operation that never finishes.
//            Built only when USB_XFER_TIMEOUT_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifdef USB_XFER_TIMEOUT_EN
module usb_xfer_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] r_count;

    // expired rises on the LIMIT-th enabled cycle after a clear
    assign expired = enable && (r_count == CNT_W'(LIMIT - 1));

    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/usb_host_xfer_ctrl.sv
// ============================================================================
// Module   : usb_host_xfer_ctrl
// Purpose  : Splits a multi-page read/write request into per-page engine
//            operations with retry. Optional macro USB_XFER_TIMEOUT_EN adds
//            an engine watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module usb_host_xfer_ctrl
    import USBPkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int PAGE_W         = DEF_PAGE_W,
    parameter int MAX_BURST      = DEF_MAX_BURST,
    parameter int MAX_RETRY      = DEF_MAX_RETRY,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [PAGE_W-1:0]              req_page,
    input  logic [$clog2(MAX_BURST+1)-1:0] req_len,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           rd_valid,
    output logic                           done,
    output logic                           done_ok,
    output logic [PAGE_W-1:0]              fail_page,
    output logic [7:0]                     retries_used,
    output logic                           eng_read_start,
    output logic                           eng_write_start,
    output logic [PAGE_W-1:0]              eng_mempage,
    output logic [DATA_W-1:0]              eng_write_data,
    input  logic                           eng_finished,
    input  logic                           eng_read_success,
    input  logic                           eng_write_success,
    input  logic [DATA_W-1:0]              eng_read_data
);

    localparam int LEN_W = $clog2(MAX_BURST + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    xfer_state_t       r_state;
    xfer_state_t       w_next;
    logic              r_write;
    logic [PAGE_W-1:0] r_page;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [RTY_W-1:0]  r_retry;
    logic [7:0]        r_retries_used;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_eng_ok;
    logic              r_done_ok;
    logic [PAGE_W-1:0] r_fail_page;
    logic [LEN_W-1:0]  w_len;
    logic              w_last;
    logic              w_can_retry;
    logic              w_timeout;

`ifdef USB_XFER_TIMEOUT_EN
    usb_xfer_watchdog #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (r_state != ST_WAIT),
        .enable  (r_state == ST_WAIT),
        .expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_len = req_len;
        if (req_len == '0) begin
            w_len = LEN_W'(1);
        end else if (req_len > LEN_W'(MAX_BURST)) begin
            w_len = LEN_W'(MAX_BURST);
        end
    end

    assign w_last      = (r_idx == r_len - 1'b1);
    assign w_can_retry = (r_retry < RTY_W'(MAX_RETRY));

    assign eng_mempage    = r_page + PAGE_W'(r_idx);
    assign eng_write_data = r_wdata;
    assign rd_data        = r_rdata;
    assign done_ok        = r_done_ok;
    assign fail_page      = r_fail_page;
    assign retries_used   = r_retries_used;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid) w_next = req_write ? ST_FETCH : ST_ISSUE;
            ST_FETCH: if (wr_valid) w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (eng_finished || w_timeout) w_next = ST_CHECK;
            ST_CHECK: begin
                if (r_eng_ok) begin
                    w_next = w_last ? ST_DONE : (r_write ? ST_FETCH : ST_ISSUE);
                end else begin
                    w_next = w_can_retry ? ST_ISSUE : ST_DONE;
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready       = (r_state == ST_IDLE);
        wr_ready        = (r_state == ST_FETCH);
        eng_read_start  = (r_state == ST_ISSUE) && !r_write;
        eng_write_start = (r_state == ST_ISSUE) && r_write;
        rd_valid        = (r_state == ST_CHECK) && !r_write && r_eng_ok;
        done            = (r_state == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_write        <= 1'b0;
            r_page         <= '0;
            r_len          <= '0;
            r_idx          <= '0;
            r_retry        <= '0;
            r_retries_used <= '0;
            r_wdata        <= '0;
            r_rdata        <= '0;
            r_eng_ok       <= 1'b0;
            r_done_ok      <= 1'b0;
            r_fail_page    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write        <= req_write;
                        r_page         <= req_page;
                        r_len          <= w_len;
                        r_idx          <= '0;
                        r_retry        <= '0;
                        r_retries_used <= '0;
                        r_done_ok      <= 1'b0;
                        r_fail_page    <= '0;
                    end
                end
                ST_FETCH: begin
                    if (wr_valid) r_wdata <= wr_data;
                end
                ST_WAIT: begin
                    // engine status is captured with eng_finished and judged in CHECK
                    if (eng_finished) begin
                        r_eng_ok <= r_write ? eng_write_success : eng_read_success;
                        if (!r_write && eng_read_success) r_rdata <= eng_read_data;
                    end else if (w_timeout) begin
                        r_eng_ok <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (r_eng_ok) begin
                        if (w_last) begin
                            r_done_ok <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_retry <= '0;
                        end
                    end else if (w_can_retry) begin
                        r_retry <= r_retry + 1'b1;
                        if (r_retries_used != 8'hFF) r_retries_used <= r_retries_used + 1'b1;
                    end else begin
                        r_fail_page <= eng_mempage;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_usb_host_xfer_ctrl.sv
// ============================================================================
// Module   : tb_usb_host_xfer_ctrl
// Purpose  : Table-driven self-checking bench for usb_host_xfer_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_usb_host_xfer_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_write;
    logic        req_ready;
    logic [15:0] req_page;
    logic [2:0]  req_len;
    logic [63:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [63:0] rd_data;
    logic        rd_valid, done, done_ok;
    logic [15:0] fail_page;
    logic [7:0]  retries_used;
    logic        eng_read_start, eng_write_start;
    logic [15:0] eng_mempage;
    logic [63:0] eng_write_data;
    logic        eng_finished, eng_read_success, eng_write_success;
    logic [63:0] eng_read_data;

    int total = 0;
    int bad   = 0;

    usb_host_xfer_ctrl dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_page          (req_page),
        .req_len           (req_len),
        .wr_data           (wr_data),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid),
        .done              (done),
        .done_ok           (done_ok),
        .fail_page         (fail_page),
        .retries_used      (retries_used),
        .eng_read_start    (eng_read_start),
        .eng_write_start   (eng_write_start),
        .eng_mempage       (eng_mempage),
        .eng_write_data    (eng_write_data),
        .eng_finished      (eng_finished),
        .eng_read_success  (eng_read_success),
        .eng_write_success (eng_write_success),
        .eng_read_data     (eng_read_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [15:0] page;
        logic [2:0]  len;
        int          fail_idx;
        int          fail_n;
        int          exp_starts;
        int          exp_hs;
        logic        exp_ok;
        logic [7:0]  exp_retries;
        logic [15:0] exp_fail_page;
        int          exp_rd;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rdpat(input logic [15:0] p);
        return 64'hDEADBEEF_CAFEF00D ^ {48'h0, p ^ 16'h0010};
    endfunction

    function automatic logic [63:0] wrpat(input int vi, input int idx);
        return {32'hA5A5_0000 + 32'(vi), 32'hC0DE_0000 + 32'(idx)};
    endfunction

    // Drives one request and plays the engine, failing page fail_idx fail_n times.
    task automatic run_vec(input vec_t v, input int vi);
        int          starts, hs, rds, idx, att, cyc;
        logic        got_done, pend, pend_ok;
        logic [15:0] pg;
        starts = 0; hs = 0; rds = 0; idx = 0; att = 0; cyc = 0;
        got_done = 1'b0; pend = 1'b0; pend_ok = 1'b0; pg = '0;
        chk($sformatf("v%0d_ready", vi), req_ready, 1'b1);
        req_valid = 1'b1; req_write = v.wr; req_page = v.page; req_len = v.len;
        @(negedge clock);
        req_valid = 1'b0;
        while (!got_done && cyc < 300) begin
            eng_finished = 1'b0;
            wr_valid     = 1'b0;
            if (pend) begin
                eng_finished      = 1'b1;
                eng_read_success  = pend_ok;
                eng_write_success = pend_ok;
                eng_read_data     = pend_ok ? rdpat(pg) : '1;
                pend = 1'b0;
            end
            if (wr_ready) begin
                hs++;
                wr_valid = 1'b1;
                wr_data  = wrpat(vi, idx);
            end
            if (eng_read_start || eng_write_start) begin
                starts++;
                pg = v.page + 16'(idx);
                chk($sformatf("v%0d_page%0d", vi, starts), eng_mempage, pg);
                chk($sformatf("v%0d_kind%0d", vi, starts), {eng_write_start, eng_read_start},
                    v.wr ? 2'b10 : 2'b01);
                if (v.wr) chk($sformatf("v%0d_wdata%0d", vi, starts), eng_write_data, wrpat(vi, idx));
                pend_ok = !(idx == v.fail_idx && att < v.fail_n);
                att++;
                if (pend_ok) begin
                    idx++;
                    att = 0;
                end
                pend = 1'b1;
            end
            if (rd_valid) begin
                rds++;
                chk($sformatf("v%0d_rdata%0d", vi, rds), rd_data, rdpat(pg));
            end
            if (done) begin
                got_done = 1'b1;
                chk($sformatf("v%0d_done_ok", vi), done_ok, v.exp_ok);
                chk($sformatf("v%0d_retries", vi), retries_used, v.exp_retries);
                chk($sformatf("v%0d_fail_page", vi), fail_page, v.exp_fail_page);
                chk($sformatf("v%0d_starts", vi), 64'(starts), 64'(v.exp_starts));
                chk($sformatf("v%0d_wr_hs", vi), 64'(hs), 64'(v.exp_hs));
                chk($sformatf("v%0d_rd_cnt", vi), 64'(rds), 64'(v.exp_rd));
            end
            @(negedge clock);
            cyc++;
        end
        eng_finished = 1'b0;
        wr_valid     = 1'b0;
        chk($sformatf("v%0d_done_seen", vi), got_done, 1'b1);
        chk($sformatf("v%0d_done_pulse", vi), done, 1'b0);
    endtask

    initial begin
        //          wr    page      len  fidx fn st hs ok    retry  fpage     rd
        vecs[0] = '{1'b0, 16'h0010, 3'd1, -1, 0, 1, 0, 1'b1, 8'd0, 16'h0000, 1};
        vecs[1] = '{1'b1, 16'h0100, 3'd3, -1, 0, 3, 3, 1'b1, 8'd0, 16'h0000, 0};
        vecs[2] = '{1'b0, 16'h0020, 3'd1,  0, 2, 3, 0, 1'b1, 8'd2, 16'h0000, 1};
        vecs[3] = '{1'b1, 16'h0200, 3'd2,  1, 4, 5, 2, 1'b0, 8'd3, 16'h0201, 0};
        vecs[4] = '{1'b0, 16'hFFFF, 3'd2, -1, 0, 2, 0, 1'b1, 8'd0, 16'h0000, 2};
        vecs[5] = '{1'b0, 16'h0030, 3'd0, -1, 0, 1, 0, 1'b1, 8'd0, 16'h0000, 1};
        vecs[6] = '{1'b0, 16'h0040, 3'd7, -1, 0, 4, 0, 1'b1, 8'd0, 16'h0000, 4};
        vecs[7] = '{1'b1, 16'h0300, 3'd1,  0, 3, 4, 1, 1'b1, 8'd3, 16'h0000, 0};
        vecs[8] = '{1'b0, 16'h0050, 3'd4,  2, 4, 6, 0, 1'b0, 8'd3, 16'h0052, 2};

        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_page = '0; req_len = '0;
        wr_data = '0; wr_valid = 1'b0; eng_finished = 1'b0; eng_read_success = 1'b0;
        eng_write_success = 1'b0; eng_read_data = '0;
        repeat (3) @(negedge clock);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_outputs", {wr_ready, rd_valid, done, done_ok, eng_read_start, eng_write_start}, 6'b0);
        chk("rst_mempage", eng_mempage, 16'h0000);
        chk("rst_retries", retries_used, 8'h00);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end

        // result of the last (failed) request holds while idle
        repeat (3) @(negedge clock);
        chk("hold_done_ok", done_ok, 1'b0);
        chk("hold_fail_page", fail_page, 16'h0052);
        chk("hold_retries", retries_used, 8'd3);

        // reset asserted in WAIT abandons the request silently
        req_valid = 1'b1; req_write = 1'b0; req_page = 16'h0077; req_len = 3'd1;
        @(negedge clock);
        req_valid = 1'b0;
        chk("rstw_issue", eng_read_start, 1'b1);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("rstw_idle", req_ready, 1'b1);
        chk("rstw_no_done", done, 1'b0);
        reset_n = 1'b1;
        eng_finished = 1'b1; eng_read_success = 1'b1; eng_read_data = 64'h1111;
        @(negedge clock);
        eng_finished = 1'b0;
        chk("stray_fin_idle", req_ready, 1'b1);
        chk("stray_fin_no_out", {rd_valid, done, done_ok}, 3'b000);
        chk("stray_fin_retries", retries_used, 8'h00);

        // request attempts while busy are ignored
        req_valid = 1'b1; req_write = 1'b0; req_page = 16'h0088; req_len = 3'd1;
        @(negedge clock);
        req_write = 1'b1;
        chk("busy_not_ready", req_ready, 1'b0);
        @(negedge clock);
        chk("busy_wait_not_ready", req_ready, 1'b0);
        eng_finished = 1'b1; eng_read_success = 1'b1; eng_read_data = rdpat(16'h0088);
        @(negedge clock);
        eng_finished = 1'b0; req_valid = 1'b0;
        chk("busy_rd_valid", rd_valid, 1'b1);
        chk("busy_rd_data", rd_data, rdpat(16'h0088));
        @(negedge clock);
        chk("busy_done", {done, done_ok}, 2'b11);
        @(negedge clock);
        chk("busy_no_second", {wr_ready, req_ready}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
